// File: rtl/dsi_crc_arb.sv
// Round-robin owner of a single byte-wide DSI long-packet CRC engine: grants one
// payload source, passes its bytes through while accumulating CRC-16, appends the footer.
module dsi_crc_arb #(
  parameter int          NUM_REQ  = 2,
  parameter int          WC_W     = 16,
  parameter logic [15:0] CRC_SEED = 16'hFFFF
) (
  input  logic                    dsi_clk,
  input  logic                    dsi_rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*WC_W-1:0] wc,
  input  logic [NUM_REQ*8-1:0]    in_data,
  input  logic [NUM_REQ-1:0]      in_valid,
  output logic [NUM_REQ-1:0]      in_ready,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    out_is_crc,
  output logic [15:0]             crc,
  output logic                    crc_done,
  output logic                    busy,
  output logic [2:0]              dbg_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshake: a byte moves on any edge where valid and ready are both high;
  // valid and data hold steady until that edge, and ready may change freely.
  typedef enum logic [2:0] {S_IDLE, S_PAYLOAD, S_CRC_LO, S_CRC_HI, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, sel_q, sel_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic [WC_W-1:0]    cnt_q, cnt_d;
  logic [15:0]        acc_q, acc_d, crc_q, crc_d;
  logic               found;
  logic [IDX_W-1:0]   win;
  logic [7:0]         sel_byte;
  logic               sel_valid;

  // Reflected CRC-16 (0x8408), LSB of the byte first, eight steps unrolled.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    end
    return r;
  endfunction

  // First requester strictly after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] idx_l;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    idx_l = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx   = (int'(ptr_q) + i) % NUM_REQ;
      idx_l = IDX_W'(idx);
      if (!found && req[idx_l]) begin
        found = 1'b1;
        win   = idx_l;
      end
    end
  end

  assign sel_byte  = in_data[int'(sel_q)*8 +: 8];
  assign sel_valid = in_valid[sel_q];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    crc_d      = crc_q;
    in_ready   = '0;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    out_last   = 1'b0;
    out_is_crc = 1'b0;
    crc_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d   = NUM_REQ'(1) << win;
          busy_d  = 1'b1;
          ptr_d   = win;
          sel_d   = win;
          cnt_d   = wc[int'(win)*WC_W +: WC_W];
          acc_d   = CRC_SEED;
          state_d = (wc[int'(win)*WC_W +: WC_W] == '0) ? S_CRC_LO : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        in_ready[sel_q] = out_ready;
        out_valid       = sel_valid;
        out_data        = sel_byte;
        if (sel_valid && out_ready) begin
          acc_d = crc_step(acc_q, sel_byte);
          cnt_d = cnt_q - WC_W'(1);
          if (cnt_q == WC_W'(1)) state_d = S_CRC_LO;
        end
      end
      S_CRC_LO: begin
        out_valid  = 1'b1;
        out_is_crc = 1'b1;
        out_data   = acc_q[7:0];
        if (out_ready) state_d = S_CRC_HI;
      end
      S_CRC_HI: begin
        out_valid  = 1'b1;
        out_is_crc = 1'b1;
        out_last   = 1'b1;
        out_data   = acc_q[15:8];
        if (out_ready) begin
          crc_d   = acc_q;
          gnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        crc_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge dsi_clk) begin
    if (dsi_rst) begin
      state_q <= S_IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      sel_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      crc_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      crc_q   <= crc_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign crc       = crc_q;
  assign dbg_state = state_q;

endmodule

// File: doc/dsi_crc_arb.md
Name: dsi_crc_arb

Overview:
- Round-robin controller that shares one byte-wide DSI long-packet CRC engine between NUM_REQ payload sources, e.g. the video pixel packer and the DCS command path.
- Grants one requester at a time and streams its payload bytes through to the lane distributor while accumulating the CRC.
- Appends the 2-byte CRC footer, then releases the engine.
- Sits between the payload sources and the lane distributor in the DSI transmit path.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- WC_W, 16, word-count width in bytes (DSI WC field).
- CRC_SEED, 16'hFFFF, CRC register value at start of every packet.

Ports:
- dsi_clk  in  1  single clock; all logic on its rising edge.
- dsi_rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-source packet request; level, held until its done.
- wc  in  NUM_REQ*WC_W  per-source payload byte count; sampled at grant.
- in_data  in  NUM_REQ*8  per-source payload byte.
- in_valid  in  NUM_REQ  per-source byte valid.
- in_ready  out  NUM_REQ  per-source byte ready; only the granted bit can be 1.
- gnt  out  NUM_REQ  one-hot grant, registered.
- out_data  out  8  byte to lane distributor.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  marks CRC high byte, the final byte of the packet.
- out_is_crc  out  1  high while a CRC byte is presented.
- crc  out  16  CRC of the last completed packet; held until the next packet completes.
- crc_done  out  1  one-cycle pulse, the cycle after the CRC high byte is accepted.
- busy  out  1  high from grant until return to IDLE.

Behaviour:
- Reset: dsi_rst high forces state IDLE and zeroes gnt, in_ready, out_data, out_valid, out_last, out_is_crc, crc, crc_done, busy and the internal counter. The round-robin pointer resets to NUM_REQ-1, so requester 0 wins first.
- Reset asserted mid-packet aborts the packet. No CRC is emitted, crc stays 0 and crc_done does not pulse.

State machine (IDLE, PAYLOAD, CRC_LO, CRC_HI, DONE):
- IDLE: if any req bit is set, pick the first set bit searching upward from pointer+1 (modulo NUM_REQ). On the next edge: set gnt, busy=1, pointer=winner, cnt=wc[winner], crc_acc=CRC_SEED. Go to PAYLOAD if wc≠0, else CRC_LO.
- PAYLOAD:
  - in_ready[g]=out_ready; out_valid=in_valid[g]; out_data=in_data[g] (combinational pass-through).
  - A transfer occurs when in_valid[g] and out_ready are both high.
  - On each transfer: crc_acc=f(crc_acc,byte) and cnt decrements.
  - The transfer that takes cnt from 1 to 0 moves the FSM to CRC_LO.
- CRC_LO: out_valid=1, out_is_crc=1, out_data=crc_acc[7:0], in_ready=0. Go to CRC_HI on out_ready.
- CRC_HI: out_data=crc_acc[15:8], out_last=1. On out_ready: crc=crc_acc, go to DONE.
- DONE: lasts one cycle. crc_done=1, gnt=0, busy=0, then IDLE. Consecutive packets are therefore separated by at least one IDLE cycle.
- CRC function f:
  - DSI CRC-16, polynomial x^16+x^12+x^5+1, reflected (0x8408).
  - Processed LSB-first, 8 bit-steps unrolled combinationally per byte.
  - No final XOR.
- Boundary conditions:
  - wc=0: no payload phase; CRC bytes are 0xFF, 0xFF.
  - wc=2^WC_W-1 must complete without counter wrap.
  - req deasserted mid-packet is ignored; the packet completes.
  - req of the granted source still high in DONE: it is treated as a new request and competes normally in IDLE.
  - out_ready low stalls any state indefinitely with out_data/out_valid stable.
  - in_valid low in PAYLOAD inserts bubbles with out_valid=0.
  - Non-granted in_ready bits are always 0.

Test Plan:
- Single source 0, wc=9, bytes "123456789" (0x31..0x39), out_ready=1 → 9 pass-through bytes, then 0x91, 0x6F with out_last on 0x6F; crc=0x6F91; crc_done pulses one cycle later.
- wc=0 on source 1 → two bytes 0xFF, 0xFF with out_is_crc=1; crc=0xFFFF.
- req=2'b11 held continuously, each wc=1 → grants alternate 0,1,0,1; each DONE is followed by one IDLE cycle.
- Random out_ready and in_valid deasserts during the "123456789" packet → same byte sequence and crc=0x6F91; out_data stable while out_ready is low.
- dsi_rst pulsed after byte 4 of a 9-byte packet → all outputs 0 next cycle, no crc_done; the following full packet yields crc=0x6F91.
- req[0] dropped after byte 2 → packet still completes with the correct CRC and gnt clears in DONE.
